// File: rtl/stream_demux_1to2.sv
// stream_demux_1to2: 1:2 valid/ready stream demultiplexer with per-output
// beat counters. Each beat is steered to output 0 or 1 by sel. Each output
// has its own one-entry register stage, so a stalled output only blocks
// beats that are routed to it.
//
// Optional feature (compile-time macro DEMUX_PKT_LOCK_EN): packet lock. The
// first beat of a multi-beat packet latches sel. The rest of the packet, up
// to and including the din_last beat, follows that latched value. When the
// macro is undefined, every beat is routed by its own sel.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   din, din_last             input beat payload and end-of-packet flag
//   din_valid, din_ready      input handshake
//   sel                       output select (0 or 1), sampled with the beat
//   dout_k, dout_k_last       registered output payload, k = 0, 1
//   dout_k_valid, dout_k_ready output handshake, k = 0, 1
//   cnt_0, cnt_1              wrap-around count of beats accepted per output
module stream_demux_1to2 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_last,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             sel,
  output logic [WIDTH-1:0] dout_0,
  output logic             dout_0_last,
  output logic             dout_0_valid,
  input  logic             dout_0_ready,
  output logic [WIDTH-1:0] dout_1,
  output logic             dout_1_last,
  output logic             dout_1_valid,
  input  logic             dout_1_ready,
  output logic [CNT_W-1:0] cnt_0,
  output logic [CNT_W-1:0] cnt_1
);

  logic eff_sel;
  logic accept;
  logic load_0, load_1;

  logic [WIDTH-1:0] data_0_q, data_1_q;
  logic             last_0_q, last_1_q;
  logic             valid_0_q, valid_0_d;
  logic             valid_1_q, valid_1_d;
  logic [CNT_W-1:0] cnt_0_q, cnt_1_q;

`ifdef DEMUX_PKT_LOCK_EN
  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e state_q, state_d;
  logic   lock_sel_q, lock_sel_d;

  assign eff_sel = (state_q == StLocked) ? lock_sel_q : sel;

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    unique case (state_q)
      StIdle: begin
        // A single-beat packet (din_last on the first beat) never locks.
        if (accept && !din_last) begin
          state_d    = StLocked;
          lock_sel_d = sel;
        end
      end
      StLocked: begin
        if (accept && din_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      lock_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end
`else
  assign eff_sel = sel;
`endif

  // Readiness looks only at the selected stage, never at din_valid.
  assign din_ready = eff_sel ? (!valid_1_q || dout_1_ready) : (!valid_0_q || dout_0_ready);
  assign accept    = din_valid && din_ready;
  assign load_0    = accept && !eff_sel;
  assign load_1    = accept && eff_sel;

  // A load wins over a drain, so drain+load in one cycle keeps valid high.
  always_comb begin
    valid_0_d = load_0 || (valid_0_q && !dout_0_ready);
    valid_1_d = load_1 || (valid_1_q && !dout_1_ready);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_0_q  <= '0;
      data_1_q  <= '0;
      last_0_q  <= 1'b0;
      last_1_q  <= 1'b0;
      valid_0_q <= 1'b0;
      valid_1_q <= 1'b0;
      cnt_0_q   <= '0;
      cnt_1_q   <= '0;
    end else begin
      valid_0_q <= valid_0_d;
      valid_1_q <= valid_1_d;
      if (load_0) begin
        data_0_q <= din;
        last_0_q <= din_last;
        cnt_0_q  <= cnt_0_q + CNT_W'(1);
      end
      if (load_1) begin
        data_1_q <= din;
        last_1_q <= din_last;
        cnt_1_q  <= cnt_1_q + CNT_W'(1);
      end
    end
  end

  assign dout_0       = data_0_q;
  assign dout_0_last  = last_0_q;
  assign dout_0_valid = valid_0_q;
  assign dout_1       = data_1_q;
  assign dout_1_last  = last_1_q;
  assign dout_1_valid = valid_1_q;
  assign cnt_0        = cnt_0_q;
  assign cnt_1        = cnt_1_q;

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Bench for stream_demux_1to2. The stimulus process drives beats and pushes
// each expected output beat into a per-output queue. A separate monitor pops
// and compares whenever an output presents a beat. A second instance with
// CNT_W=2 shares the inputs to observe counter wrap.
module tb_stream_demux_1to2;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] din;
  logic         din_last, din_valid, din_ready, sel;
  logic [W-1:0] dout_0, dout_1;
  logic         dout_0_last, dout_0_valid, dout_0_ready;
  logic         dout_1_last, dout_1_valid, dout_1_ready;
  logic [15:0]  cnt_0, cnt_1;

  logic         s_din_ready;
  logic [W-1:0] s_dout_0, s_dout_1;
  logic         s_dout_0_last, s_dout_0_valid, s_dout_1_last, s_dout_1_valid;
  logic [1:0]   s_cnt_0, s_cnt_1;

  always #5 clk = ~clk;

  stream_demux_1to2 #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_last(din_last),
    .din_valid(din_valid), .din_ready(din_ready), .sel(sel),
    .dout_0(dout_0), .dout_0_last(dout_0_last), .dout_0_valid(dout_0_valid),
    .dout_0_ready(dout_0_ready), .dout_1(dout_1), .dout_1_last(dout_1_last),
    .dout_1_valid(dout_1_valid), .dout_1_ready(dout_1_ready),
    .cnt_0(cnt_0), .cnt_1(cnt_1)
  );

  stream_demux_1to2 #(.WIDTH(W), .CNT_W(2)) dut_small (
    .clk(clk), .reset_n(reset_n), .din(din), .din_last(din_last),
    .din_valid(din_valid), .din_ready(s_din_ready), .sel(sel),
    .dout_0(s_dout_0), .dout_0_last(s_dout_0_last), .dout_0_valid(s_dout_0_valid),
    .dout_0_ready(dout_0_ready), .dout_1(s_dout_1), .dout_1_last(s_dout_1_last),
    .dout_1_valid(s_dout_1_valid), .dout_1_ready(dout_1_ready),
    .cnt_0(s_cnt_0), .cnt_1(s_cnt_1)
  );

  // Reference model state
  logic [W:0]  q0[$];
  logic [W:0]  q1[$];
  bit          occ[2];
  logic [15:0] mcnt[2];
  bit          in_pkt, pkt_sel;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    occ[0]  = 0;
    occ[1]  = 0;
    mcnt[0] = '0;
    mcnt[1] = '0;
    in_pkt  = 0;
    pkt_sel = 0;
  endtask

  // One cycle: drive inputs after the falling edge, check state before the
  // next rising edge, then advance the model as that edge will.
  task automatic beat(input bit v, input bit s, input logic [W-1:0] d, input bit l,
                      input bit r0, input bit r1);
    bit k, exp_rdy, acc;
    @(negedge clk);
    din_valid    = v;
    sel          = s;
    din          = d;
    din_last     = l;
    dout_0_ready = r0;
    dout_1_ready = r1;
    #2;
    check("dout_0_valid", dout_0_valid, occ[0]);
    check("dout_1_valid", dout_1_valid, occ[1]);
    check("cnt_0", cnt_0, mcnt[0]);
    check("cnt_1", cnt_1, mcnt[1]);
    check("small_cnt_1", s_cnt_1, mcnt[1] % 4);
    k = s;
`ifdef DEMUX_PKT_LOCK_EN
    if (in_pkt) k = pkt_sel;
`endif
    exp_rdy = !occ[k] || (k ? r1 : r0);
    check("din_ready", din_ready, exp_rdy);
    acc = v && exp_rdy;
    if (occ[0] && r0) occ[0] = 0;
    if (occ[1] && r1) occ[1] = 0;
    if (acc) begin
      if (k) q1.push_back({l, d});
      else   q0.push_back({l, d});
      occ[k]  = 1;
      mcnt[k] = mcnt[k] + 16'd1;
`ifdef DEMUX_PKT_LOCK_EN
      if (!in_pkt && !l) begin
        in_pkt  = 1;
        pkt_sel = s;
      end else if (in_pkt && l) begin
        in_pkt = 0;
      end
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    din_valid = 0;
    reset_n   = 0;
    #1;
    check("rst_valid_0", dout_0_valid, 0);
    check("rst_valid_1", dout_1_valid, 0);
    check("rst_cnt_0", cnt_0, 0);
    check("rst_cnt_1", cnt_1, 0);
    check("rst_small_cnt_1", s_cnt_1, 0);
    model_clear();
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic rand_beats(input int n);
    for (int i = 0; i < n; i++) begin
      beat($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end
  endtask

  // Monitor: every presented beat must match the oldest expected beat.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (reset_n === 1'b1) begin
        if (dout_0_valid) begin
          if (q0.size() == 0) check("out0_unexpected", {dout_0_last, dout_0}, 'x);
          else begin
            check("out0_beat", {dout_0_last, dout_0}, q0[0]);
            if (dout_0_ready) void'(q0.pop_front());
          end
        end
        if (dout_1_valid) begin
          if (q1.size() == 0) check("out1_unexpected", {dout_1_last, dout_1}, 'x);
          else begin
            check("out1_beat", {dout_1_last, dout_1}, q1[0]);
            if (dout_1_ready) void'(q1.pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset_n = 0; din = '0; din_last = 0; din_valid = 0; sel = 0;
    dout_0_ready = 0; dout_1_ready = 0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1;

    // Two back-to-back beats to output 0
    beat(1, 0, 8'hA5, 0, 1, 1);
    beat(1, 0, 8'h3C, 1, 1, 1);
    beat(0, 0, 8'h00, 0, 1, 1);
    beat(0, 0, 8'h00, 0, 1, 1);

    // Stalled output 0 blocks only beats routed to it
    beat(1, 0, 8'h11, 1, 0, 1);
    beat(1, 0, 8'h22, 1, 0, 1);
    beat(1, 0, 8'h22, 1, 0, 1);
    beat(1, 1, 8'h33, 1, 0, 1);
    beat(0, 0, 8'h00, 0, 1, 1);
    beat(0, 0, 8'h00, 0, 1, 1);

    // Counter wrap on the CNT_W=2 instance: 1,2,3,0,1
    do_reset();
    for (int i = 0; i < 5; i++) beat(1, 1, 8'(8'h40 + i), 1, 1, 1);
    beat(0, 0, 8'h00, 0, 1, 1);

    // Packet with sel toggling mid-packet, then a single-beat packet on sel=0
    beat(1, 1, 8'hB1, 0, 1, 1);
    beat(1, 0, 8'hB2, 0, 1, 1);
    beat(1, 1, 8'hB3, 1, 1, 1);
    beat(1, 0, 8'hC1, 1, 1, 1);
    beat(0, 0, 8'h00, 0, 1, 1);
    beat(0, 0, 8'h00, 0, 1, 1);

    // Random traffic, mid-traffic reset, more random traffic
    rand_beats(400);
    do_reset();
    beat(0, 0, 8'h00, 0, 0, 0);
    rand_beats(1500);

    // Drain and confirm nothing was left behind
    repeat (4) beat(0, 0, 8'h00, 0, 1, 1);
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
